// File: rtl/oled_spi_ctrl.sv
// oled_spi_ctrl: SSD1306 OLED power-up sequencer and write-only SPI mode 0 byte serialiser.
// Define OLED_SPI_INIT_ROM_EN to stream the built-in 8-byte init command list after reset.
module oled_spi_ctrl #(
  parameter int CLK_DIV    = 4,
  parameter int RST_CYCLES = 1000,
  parameter int RST_WAIT   = 1000
) (
  input  logic       i_Clk,
  input  logic       i_Rst_n,
  input  logic [7:0] i_Byte,
  input  logic       i_DC,
  input  logic       i_Valid,
  output logic       o_Ready,
  output logic       o_Init_Done,
  output logic       o_Res,
  output logic       o_CS1_n,
  output logic       o_DC,
  output logic       o_CS2_n,
  output logic       o_D0,
  output logic       o_D1
);
  localparam int DW   = $clog2(CLK_DIV) + 1;
  localparam int RMAX = (RST_CYCLES > RST_WAIT) ? RST_CYCLES : RST_WAIT;
  localparam int RCW  = $clog2(RMAX + 1);
  typedef enum logic [2:0] {S_RST_LOW, S_RST_WAIT, S_IDLE, S_SHIFT, S_GAP} state_t;
  state_t state, nxt;
  logic [RCW-1:0] rcnt;
  logic [DW-1:0] div;
  logic [2:0] bit_cnt;
  logic phase;
  logic [7:0] sh;
  logic dc_q;
  logic done;
  logic more;
  logic rst_end, wait_end, div_end, bit_tick, last_bit;
  assign rst_end  = rcnt == RCW'(RST_CYCLES - 1);
  assign wait_end = rcnt == RCW'(RST_WAIT - 1);
  assign div_end  = div == DW'(CLK_DIV - 1);
  assign bit_tick = state == S_SHIFT && phase && div_end;
  assign last_bit = bit_tick && bit_cnt == 3'd7;
`ifdef OLED_SPI_INIT_ROM_EN
  logic [2:0] idx;
  logic init_run;
  function automatic logic [7:0] rom(input logic [2:0] i);
    case (i)
      3'd0: rom = 8'hAE;
      3'd1: rom = 8'hD5;
      3'd2: rom = 8'h80;
      3'd3: rom = 8'hA8;
      3'd4: rom = 8'h3F;
      3'd5: rom = 8'h8D;
      3'd6: rom = 8'h14;
      default: rom = 8'hAF;
    endcase
  endfunction
  assign more = init_run && idx != 3'd7;
`else
  assign more = 1'b0;
`endif
  // Next-state logic: the init list reuses the SHIFT/GAP framing, chaining bytes without visiting IDLE.
  always_comb begin
    nxt = state;
    case (state)
      S_RST_LOW:  nxt = rst_end ? S_RST_WAIT : S_RST_LOW;
`ifdef OLED_SPI_INIT_ROM_EN
      S_RST_WAIT: nxt = wait_end ? S_SHIFT : S_RST_WAIT;
`else
      S_RST_WAIT: nxt = wait_end ? S_IDLE : S_RST_WAIT;
`endif
      S_IDLE:     nxt = i_Valid ? S_SHIFT : S_IDLE;
      S_SHIFT:    nxt = last_bit ? S_GAP : S_SHIFT;
      S_GAP:      nxt = div_end ? (more ? S_SHIFT : S_IDLE) : S_GAP;
      default:    nxt = S_RST_LOW;
    endcase
  end
  // State register, counters and shift register; every counter reloads to zero when its state ends.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      state   <= S_RST_LOW;
      rcnt    <= '0;
      div     <= '0;
      phase   <= 1'b0;
      bit_cnt <= '0;
      sh      <= '0;
      dc_q    <= 1'b0;
      done    <= 1'b0;
`ifdef OLED_SPI_INIT_ROM_EN
      idx      <= '0;
      init_run <= 1'b0;
`endif
    end else begin
      state   <= nxt;
      rcnt    <= ((state == S_RST_LOW && !rst_end) || (state == S_RST_WAIT && !wait_end)) ? rcnt + 1'b1 : '0;
      div     <= ((state == S_SHIFT || state == S_GAP) && !div_end) ? div + 1'b1 : '0;
      phase   <= (state == S_SHIFT) ? phase ^ div_end : 1'b0;
      bit_cnt <= (state == S_SHIFT && !last_bit) ? bit_cnt + {2'b00, bit_tick} : '0;
      done    <= done | (nxt == S_IDLE);
      if (state == S_IDLE && i_Valid) begin
        sh   <= i_Byte;
        dc_q <= i_DC;
      end else if (bit_tick) begin
        sh <= {sh[6:0], 1'b0};
      end
`ifdef OLED_SPI_INIT_ROM_EN
      if (state == S_RST_WAIT && wait_end) begin
        sh       <= rom(3'd0);
        dc_q     <= 1'b0;
        idx      <= '0;
        init_run <= 1'b1;
      end
      if (state == S_GAP && div_end) begin
        init_run <= more;
        if (more) begin
          idx <= idx + 1'b1;
          sh  <= rom(idx + 1'b1);
        end
      end
`endif
    end
  end
  assign o_Ready     = state == S_IDLE;
  assign o_Init_Done = done;
  assign o_Res       = state != S_RST_LOW;
  assign o_CS1_n     = state != S_SHIFT;
  assign o_DC        = dc_q;
  assign o_CS2_n     = 1'b1;
  assign o_D0        = state == S_SHIFT && phase;
  assign o_D1        = state == S_SHIFT && sh[7];
endmodule

// File: tb/tb_oled_spi_ctrl.sv
// tb_oled_spi_ctrl: randomized self-checking bench for oled_spi_ctrl against a cycle-timing model.
module tb_oled_spi_ctrl;
  localparam int CD = 2;
  localparam int RC = 4;
  localparam int RW = 3;
  localparam int FL = 17 * CD;
`ifdef OLED_SPI_INIT_ROM_EN
  localparam int IT = 8 * FL;
`else
  localparam int IT = 0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] byte_in = 8'h00;
  logic dc = 1'b0;
  logic valid = 1'b0;
  logic ready, init_done, res, cs1_n, dc_out, cs2_n, d0, d1;
  int checks = 0;
  int errors = 0;
  logic mon = 1'b0;
  always #5 clk = ~clk;
  oled_spi_ctrl #(.CLK_DIV(CD), .RST_CYCLES(RC), .RST_WAIT(RW)) dut (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Byte(byte_in), .i_DC(dc), .i_Valid(valid),
    .o_Ready(ready), .o_Init_Done(init_done), .o_Res(res), .o_CS1_n(cs1_n),
    .o_DC(dc_out), .o_CS2_n(cs2_n), .o_D0(d0), .o_D1(d1)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // Model: time since reset release, position inside the current frame, init-list progress.
  int age = 0;
  int ft = 0;
  int it = 0;
  logic [7:0] fb = 8'h00;
  logic fdc = 1'b0;
  logic mdone = 1'b0;
  logic [7:0] rom [8] = '{8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'h8D, 8'h14, 8'hAF};
  logic m_ready;
  assign m_ready = mdone && ft == 0;
  always @(posedge clk) begin
    if (!rst_n) begin
      age <= 0; ft <= 0; it <= 0; mdone <= 1'b0;
    end else begin
      if (age < 100000) age <= age + 1;
      if (IT == 0 && age + 1 == RC + RW) mdone <= 1'b1;
      if (IT > 0 && age + 1 == RC + RW) it <= 1;
      else if (it > 0 && it <= IT) it <= it + 1;
      if (IT > 0 && it == IT) mdone <= 1'b1;
      if (ft > 0) ft <= (ft == FL) ? 0 : ft + 1;
      else if (m_ready && valid) begin
        ft <= 1; fb <= byte_in; fdc <= dc;
      end
    end
  end
  int e_loc;
  logic [7:0] e_b;
  logic e_d, e_act, e_sh, e_d0, e_d1;
  always_comb begin
    e_loc = 0; e_b = 8'h00; e_d = 1'b0; e_act = 1'b0;
    if (ft > 0) begin
      e_act = 1'b1; e_loc = ft; e_b = fb; e_d = fdc;
    end else if (it > 0 && it <= IT) begin
      e_act = 1'b1; e_loc = (it - 1) % FL + 1; e_b = rom[(it - 1) / FL]; e_d = 1'b0;
    end
    e_sh = e_act && e_loc <= 16 * CD;
    e_d0 = e_sh && ((e_loc - 1) / CD) % 2 == 1;
    e_d1 = e_sh ? e_b[3'(7 - (e_loc - 1) / (2 * CD))] : 1'b0;
  end
  // Per-cycle comparison of every output against the model, away from the active edge.
  always @(negedge clk) begin
    if (mon) begin
      chk("res", res, age >= RC);
      chk("cs1_n", cs1_n, !e_sh);
      chk("cs2_n", cs2_n, 1);
      chk("d0", d0, e_d0);
      chk("ready", ready, m_ready);
      chk("init_done", init_done, mdone);
      if (e_sh) begin
        chk("d1", d1, e_d1);
        chk("dc", dc_out, e_d);
      end else if (age < RC) begin
        chk("d1_rst", d1, 0);
        chk("dc_rst", dc_out, 0);
      end
    end
  end
  // Byte decoder: sample D1 on each D0 rise inside a CS1_n-low frame.
  logic [7:0] dsr = 8'h00;
  int dbits = 0;
  logic pd0 = 1'b0;
  logic [7:0] cap [$];
  always @(negedge clk) begin
    pd0 <= d0;
    if (cs1_n) dbits <= 0;
    else if (d0 && !pd0) begin
      dsr <= {dsr[6:0], d1};
      if (dbits == 7) begin
        cap.push_back({dsr[6:0], d1});
        dbits <= 0;
      end else dbits <= dbits + 1;
    end
  end
  task automatic wait_hs();
    int n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (ft != 1 && n < 400);
    chk("hs_wait", ft == 1, 1);
  endtask
  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n < 2000) begin
      @(posedge clk); #1; n++;
    end
  endtask
  logic [7:0] sent [$];
  int n, lows, first_res;
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_res", res, 0); chk("rst_cs1", cs1_n, 1); chk("rst_cs2", cs2_n, 1); chk("rst_dc", dc_out, 0);
    chk("rst_d0", d0, 0); chk("rst_d1", d1, 0); chk("rst_ready", ready, 0); chk("rst_done", init_done, 0);
    mon = 1'b1;
    rst_n = 1'b1;
    n = 0; first_res = 0;
    while (!ready && n < 2000) begin
      @(posedge clk); #1; n++;
      if (res && first_res == 0) first_res = n;
    end
    chk("res_rise", first_res, 4);
`ifdef OLED_SPI_INIT_ROM_EN
    chk("ready_latency", n, 7 + 8 * 34);
    chk("init_count", cap.size(), 8);
    for (int i = 0; i < 8 && i < cap.size(); i++) chk("init_byte", cap[i], rom[i]);
`else
    chk("ready_latency", n, 7);
    chk("init_count", cap.size(), 0);
`endif
    cap.delete();
    byte_in = 8'hA5; dc = 1'b1; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    n = 0; lows = 0;
    while (n < 200) begin
      @(negedge clk); n++;
      if (!cs1_n) lows++;
      if (ready) break;
    end
    chk("a5_cs_low", lows, 32);
    chk("a5_ready_back", n, 35);
    chk("a5_count", cap.size(), 1);
    if (cap.size() > 0) chk("a5_byte", cap[0], 8'hA5);
    @(posedge clk); #1;
    cap.delete();
    byte_in = 8'h00; dc = 1'b0; valid = 1'b1;
    wait_hs();
    byte_in = 8'hFF;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (ft != 1 && n < 400);
    chk("b2b_period", n, 35);
    valid = 1'b0;
    wait_ready(n);
    chk("b2b_count", cap.size(), 2);
    if (cap.size() == 2) begin
      chk("b2b_first", cap[0], 8'h00);
      chk("b2b_second", cap[1], 8'hFF);
    end
    cap.delete();
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
      byte_in = 8'($urandom); dc = 1'($urandom); valid = 1'b1;
      sent.push_back(byte_in);
      wait_hs();
      valid = 1'b0;
    end
    wait_ready(n);
    chk("rand_count", cap.size(), sent.size());
    for (int i = 0; i < sent.size() && i < cap.size(); i++) chk("rand_byte", cap[i], sent[i]);
    byte_in = 8'h3C; dc = 1'b1; valid = 1'b1;
    wait_hs();
    valid = 1'b0;
    repeat (8 * CD) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mid_cs1", cs1_n, 1); chk("mid_d0", d0, 0); chk("mid_res", res, 0);
    chk("mid_done", init_done, 0); chk("mid_ready", ready, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_ready(n);
    chk("rerun_latency", n, RC + RW + IT);
    chk("rerun_done", init_done, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
